engine_input_conditioner: RTL and testbench



---
 rtl/engine_pkg.sv | 5 +
 rtl/sync_debounce.sv | 36 +++
 rtl/engine_input_conditioner.sv | 95 +++++++++
 tb/tb_engine_input_conditioner.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/engine_pkg.sv
// engine_pkg: shared types and widths for the engine start/stop front end.
package engine_pkg;
   localparam int PERIOD_W = 16;
   typedef enum logic [1:0] {STOPPED, QUALIFYING, RUNNING} tach_state_e;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: two-flop synchroniser, debounce counter and registered rise pulse.
module sync_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d, rise_q, rise_d, mismatch, done;
   always_comb begin
      mismatch = sync_q[1] != level_q;
      done     = mismatch && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
      cnt_d    = (!mismatch || done) ? '0 : cnt_q + CW'(1);
      level_d  = done ? sync_q[1] : level_q;
      rise_d   = done & sync_q[1];
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], raw_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
      end
   assign level_o = level_q;
   assign rise_o  = rise_q;
endmodule

// File: rtl/engine_input_conditioner.sv
// engine_input_conditioner: debounced start/stop button and tach-qualified
// engine-running level with measured tach period.
module engine_input_conditioner
   import engine_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TACH_TIMEOUT    = 1000,
   parameter int TACH_MIN_PULSES = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                button_raw_i,
   input  logic                tach_raw_i,
   output logic                button_o,
   output logic                button_rise_o,
   output logic                sense_o,
   output logic [PERIOD_W-1:0] tach_period_o
);
   localparam int GW = $clog2(TACH_MIN_PULSES + 1);
   logic [1:0]          tach_sync_q;
   logic                tach_d_q, tach_s, tach_edge, timeout, sense_q;
   logic [PERIOD_W-1:0] gap_q, gap_d, period_q;
   logic [GW-1:0]       good_q, good_inc;
   tach_state_e         state_q;

   sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_button (
      .clock  (clock),
      .reset  (reset),
      .raw_i  (button_raw_i),
      .level_o(button_o),
      .rise_o (button_rise_o)
   );

   // An edge in the would-timeout cycle is still an in-time period.
   always_comb begin
      tach_s    = tach_sync_q[1];
      tach_edge = tach_s & ~tach_d_q;
      timeout   = !tach_edge && gap_q == PERIOD_W'(TACH_TIMEOUT - 1);
      gap_d     = tach_edge ? '0 : gap_q == PERIOD_W'(TACH_TIMEOUT) ? gap_q : gap_q + PERIOD_W'(1);
      good_inc  = good_q + GW'(1);
   end

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         tach_sync_q <= '0;
         tach_d_q    <= 1'b0;
         gap_q       <= '0;
      end else begin
         tach_sync_q <= {tach_sync_q[0], tach_raw_i};
         tach_d_q    <= tach_s;
         gap_q       <= gap_d;
      end

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state_q  <= STOPPED;
         good_q   <= '0;
         sense_q  <= 1'b0;
         period_q <= '0;
      end else begin
         case (state_q)
            STOPPED:
               if (tach_edge) begin
                  state_q <= QUALIFYING;
                  good_q  <= '0;
               end
            QUALIFYING:
               if (tach_edge) begin
                  period_q <= gap_q + PERIOD_W'(1);
                  good_q   <= good_inc;
                  if (good_inc == GW'(TACH_MIN_PULSES)) begin
                     state_q <= RUNNING;
                     sense_q <= 1'b1;
                  end
               end else if (timeout) begin
                  state_q  <= STOPPED;
                  good_q   <= '0;
                  period_q <= '0;
               end
            RUNNING:
               if (tach_edge)
                  period_q <= gap_q + PERIOD_W'(1);
               else if (timeout) begin
                  state_q  <= STOPPED;
                  good_q   <= '0;
                  sense_q  <= 1'b0;
                  period_q <= '0;
               end
            default: state_q <= STOPPED;
         endcase
      end

   assign sense_o       = sense_q;
   assign tach_period_o = period_q;
endmodule

// File: tb/tb_engine_input_conditioner.sv
// tb_engine_input_conditioner: scoreboard bench; expectations are queued with
// the cycle they are due and compared on the falling edge of that cycle.
module tb_engine_input_conditioner;
   logic        clock = 1'b0, reset = 1'b1, button_raw = 1'b0, tach_raw = 1'b0;
   logic        button, button_rise, sense;
   logic [15:0] tach_period;
   int          cyc = 0, checks = 0, errors = 0, rise_cnt = 0;

   typedef struct {int cyc; string tag; int sig; int val;} sb_t;
   sb_t sb[$];

   engine_input_conditioner #(.DEBOUNCE_CYCLES(4), .TACH_TIMEOUT(20), .TACH_MIN_PULSES(3)) dut (
      .clock        (clock),
      .reset        (reset),
      .button_raw_i (button_raw),
      .tach_raw_i   (tach_raw),
      .button_o     (button),
      .button_rise_o(button_rise),
      .sense_o      (sense),
      .tach_period_o(tach_period)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   function automatic void sb_push(input int c, input string t, input int s, input int v);
      sb.push_back('{c, t, s, v});
   endfunction

   function automatic logic [31:0] obs_of(input int s);
      return s == 0 ? 32'(button) : s == 1 ? 32'(button_rise) : s == 2 ? 32'(sense) : 32'(tach_period);
   endfunction

   always @(negedge clock) begin
      if (button_rise) rise_cnt++;
      for (int i = sb.size() - 1; i >= 0; i--)
         if (sb[i].cyc == cyc) begin
            check(sb[i].tag, obs_of(sb[i].sig), 32'(sb[i].val));
            sb.delete(i);
         end
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   task automatic tach_train(input int n, input int per);
      for (int p = 0; p < n; p++) begin
         tach_raw = 1'b1;
         repeat (2) @(negedge clock);
         tach_raw = 1'b0;
         repeat (per - 2) @(negedge clock);
      end
   endtask

   initial begin
      int c;
      logic [6:0] pat;
      repeat (3) @(negedge clock);
      check("rst_button", button, 0);
      check("rst_rise", button_rise, 0);
      check("rst_sense", sense, 0);
      check("rst_period", tach_period, 0);
      reset = 1'b0;
      @(negedge clock);
      // Button press and release
      c = cyc;
      button_raw = 1'b1;
      sb_push(c + 5, "press_early", 0, 0);
      sb_push(c + 5, "press_norise", 1, 0);
      sb_push(c + 6, "press_level", 0, 1);
      sb_push(c + 6, "press_rise", 1, 1);
      sb_push(c + 7, "press_hold", 0, 1);
      sb_push(c + 7, "press_rise_end", 1, 0);
      wait_until(c + 10);
      c = cyc;
      button_raw = 1'b0;
      sb_push(c + 5, "release_early", 0, 1);
      sb_push(c + 6, "release_level", 0, 0);
      sb_push(c + 6, "release_norise", 1, 0);
      wait_until(c + 10);
      check("rise_count_t1", rise_cnt, 1);
      // Glitches shorter than the debounce window
      c = cyc;
      pat = 7'b0110111;
      for (int j = 1; j <= 16; j++) begin
         sb_push(c + j, "glitch_level", 0, 0);
         sb_push(c + j, "glitch_rise", 1, 0);
      end
      for (int j = 0; j < 7; j++) begin
         button_raw = pat[j];
         @(negedge clock);
      end
      wait_until(c + 17);
      check("rise_count_t2", rise_cnt, 1);
      // Qualify at period 10, then stop and time out
      c = cyc;
      sb_push(c + 13, "q10_period", 3, 10);
      sb_push(c + 13, "q10_sense_lo", 2, 0);
      sb_push(c + 32, "q10_sense_pre", 2, 0);
      sb_push(c + 33, "q10_sense", 2, 1);
      sb_push(c + 33, "q10_period4", 3, 10);
      sb_push(c + 72, "to_sense_hold", 2, 1);
      sb_push(c + 72, "to_period_hold", 3, 10);
      sb_push(c + 73, "to_sense", 2, 0);
      sb_push(c + 73, "to_period", 3, 0);
      tach_train(6, 10);
      wait_until(c + 80);
      // Period exactly at the timeout boundary still qualifies
      c = cyc;
      sb_push(c + 23, "q20_period", 3, 20);
      sb_push(c + 23, "q20_sense_lo", 2, 0);
      sb_push(c + 62, "q20_sense_pre", 2, 0);
      sb_push(c + 63, "q20_sense", 2, 1);
      sb_push(c + 63, "q20_period4", 3, 20);
      tach_train(4, 20);
      wait_until(c + 90);
      check("q20_stopped", sense, 0);
      // Period one past the timeout never qualifies
      c = cyc;
      for (int j = 0; j < 6; j++) begin
         sb_push(c + 21 * j + 3, "p21_sense", 2, 0);
         sb_push(c + 21 * j + 4, "p21_period", 3, 0);
      end
      tach_train(6, 21);
      wait_until(c + 130);
      // Reset while running with button held
      c = cyc;
      button_raw = 1'b1;
      sb_push(c + 6, "t6_button", 0, 1);
      wait_until(c + 10);
      c = cyc;
      sb_push(c + 33, "t6_sense", 2, 1);
      sb_push(c + 37, "t6_button_hold", 0, 1);
      tach_train(4, 10);
      check("pre_rst_sense", sense, 1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_button", button, 0);
      check("mid_rst_rise", button_rise, 0);
      check("mid_rst_sense", sense, 0);
      check("mid_rst_period", tach_period, 0);
      @(negedge clock);
      reset = 1'b0;
      c = cyc;
      sb_push(c + 5, "post_rst_early", 0, 0);
      sb_push(c + 6, "post_rst_button", 0, 1);
      sb_push(c + 6, "post_rst_rise", 1, 1);
      sb_push(c + 7, "post_rst_rise_end", 1, 0);
      sb_push(c + 32, "post_rst_sense_pre", 2, 0);
      sb_push(c + 33, "post_rst_sense", 2, 1);
      sb_push(c + 33, "post_rst_period", 3, 10);
      tach_train(4, 10);
      wait_until(c + 45);
      check("rise_count_end", rise_cnt, 3);
      check("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
